// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-command encodings and sequencer states for the RAM port arbiter.
// No logic; constants and one decode helper only.
// Encodings match the CPU FSM's MREAD/MWRITE values.
package mem_arb_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_e;

  // True only for commands that actually touch the RAM; 00 and 11 do not.
  function automatic logic is_access(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both masters' request ports, the RAM port and the status outputs.
// Pure wiring, no latency.
// req/ack handshake: a master holds its request fields stable until ack.
interface mem_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);

  logic          req0;
  logic          req1;
  logic [1:0]    cmd0;
  logic [1:0]    cmd1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          grant;
  logic          busy;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;

  // Arbiter side.
  modport slave (
    input  req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, read_data,
    output ack0, ack1, rdata, grant, busy, mem_cmd, mem_addr, write_data
  );

  // Environment side: the two masters plus the RAM.
  modport master (
    output req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, read_data,
    input  ack0, ack1, rdata, grant, busy, mem_cmd, mem_addr, write_data
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin winner selection for the RAM port.
// Combinational, zero latency.
// No backpressure; the parent decides when the result is used.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       win,
  output logic       any
);

  // On a tie the master that was not served last wins; otherwise the lone requester.
  always_comb begin
    any = |req;
    if (req == 2'b11) begin
      win = ~last_grant;
    end else begin
      win = req[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM between the CPU port (0) and a DMA/IO port (1).
// Request sampled in IDLE; ack after 3 cycles for reads, 2 for writes/none/illegal.
// One transaction in flight; the other master's req simply waits until IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic [1:0]    cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          grant_q;
  logic          last_grant_q;

  logic          win;
  logic          any;
  logic          load;
  logic [1:0]    mem_cmd_d;
  logic          ack0_d;
  logic          ack1_d;

  rr_arbiter2 u_rr (
    .req        ({bus.req1, bus.req0}),
    .last_grant (last_grant_q),
    .win        (win),
    .any        (any)
  );

  // Sequencer state register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and RAM/ack decode; mem_cmd is MNONE outside ISSUE/CAPTURE.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    mem_cmd_d = MNONE;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_cmd_d = is_access(cmd_q) ? cmd_q : MNONE;
        state_d   = (cmd_q == MREAD) ? CAPTURE : ACK;
      end
      CAPTURE: begin
        mem_cmd_d = MREAD;
        state_d   = ACK;
      end
      ACK: begin
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the winner's request so a master dropping req early cannot corrupt it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q   <= MNONE;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= 1'b0;
    end else if (load) begin
      if (win) begin
        cmd_q   <= bus.cmd1;
        addr_q  <= bus.addr1;
        wdata_q <= bus.wdata1;
      end else begin
        cmd_q   <= bus.cmd0;
        addr_q  <= bus.addr0;
        wdata_q <= bus.wdata0;
      end
      grant_q <= win;
    end
  end

  // Read data arrives the cycle after MREAD is presented, i.e. during CAPTURE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (state_q == CAPTURE) begin
      rdata_q <= bus.read_data;
    end
  end

  // Fairness history moves only on completion, so abandoned transactions do not count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (state_q == ACK) begin
      last_grant_q <= grant_q;
    end
  end

  assign bus.ack0       = ack0_d;
  assign bus.ack1       = ack1_d;
  assign bus.rdata      = rdata_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.mem_cmd    = mem_cmd_d;
  assign bus.mem_addr   = addr_q;
  assign bus.write_data = wdata_q;

endmodule
